gumnut_port_responder: RTL and testbench

//   Responder end of the CPU I/O port bus: decodes port_adr, completes port

---
 rtl/gumnut_port_pkg.sv | 30 +++
 rtl/port_timer.sv | 136 +++++++++++++
 rtl/gumnut_port_responder.sv | 147 ++++++++++++++
 tb/tb_gumnut_port_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gumnut_port_pkg.sv
// -----------------------------------------------------------------------------
// gumnut_port_pkg
//   Shared definitions for the Gumnut port-bus responder: register offsets
//   within the 4-register window, CTRL register bit positions and the packed
//   layout of the CTRL register.
//
//   Optional feature macro: GUMNUT_PORT_TIMER_EN (used by the importing files).
// -----------------------------------------------------------------------------
package gumnut_port_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [1:0] OFF_LED    = 2'd0;
    localparam logic [1:0] OFF_SW     = 2'd1;
    localparam logic [1:0] OFF_RELOAD = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    // CTRL register bit indices
    localparam int CTRL_TMR_EN  = 0;
    localparam int CTRL_INT_EN  = 1;
    localparam int CTRL_EXPIRED = 7;

    // CTRL register as seen on a read
    typedef struct packed {
        logic       expired;   // bit 7, write-1-to-clear
        logic [4:0] rsvd;      // bits 6..2, always read as 0
        logic       int_en;    // bit 1
        logic       tmr_en;    // bit 0
    } ctrl_t;

endpackage : gumnut_port_pkg

// File: rtl/port_timer.sv
// -----------------------------------------------------------------------------
// port_timer
//   Reloadable interval timer for the Gumnut port responder. A prescaler
//   divides clk_i by PRESCALE to produce ticks; each tick decrements an 8-bit
//   counter, and a tick seen at count 0 sets the expired flag and reloads the
//   counter from RELOAD. expired is cleared by int_ack_i or by writing 1 to
//   CTRL bit 7; a set and a clear in the same cycle leave it set.
//   Only instantiated when GUMNUT_PORT_TIMER_EN is defined.
//
// Ports
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   reload_we_i  in   write strobe for RELOAD (one cycle per bus write)
//   ctrl_we_i    in   write strobe for CTRL   (one cycle per bus write)
//   wdat_i       in   8-bit write data from the bus
//   int_ack_i    in   CPU interrupt acknowledge, clears expired
//   reload_o     out  current RELOAD register value
//   ctrl_o       out  current CTRL register value (ctrl_t layout)
//   int_req_o    out  registered expired & int_en
// -----------------------------------------------------------------------------
module port_timer
    import gumnut_port_pkg::*;
#(
    parameter int PRESCALE = 256
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       reload_we_i,
    input  logic       ctrl_we_i,
    input  logic [7:0] wdat_i,
    input  logic       int_ack_i,
    output logic [7:0] reload_o,
    output ctrl_t      ctrl_o,
    output logic       int_req_o
);

    localparam int            PW        = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q,   presc_d;
    logic [7:0]    count_q,   count_d;
    logic [7:0]    reload_q,  reload_d;
    logic          tmr_en_q,  tmr_en_d;
    logic          int_en_q,  int_en_d;
    logic          expired_q, expired_d;
    logic          int_req_q, int_req_d;

    logic          tick;
    logic          expire_set;
    logic          expire_clr;

    always_comb begin
        reload_d   = reload_q;
        tmr_en_d   = tmr_en_q;
        int_en_d   = int_en_q;
        presc_d    = presc_q;
        count_d    = count_q;
        expire_set = 1'b0;
        expire_clr = 1'b0;
        tick       = tmr_en_q && (presc_q == PRESC_MAX);

        if (reload_we_i) begin
            reload_d = wdat_i;
        end

        if (ctrl_we_i) begin
            tmr_en_d = wdat_i[CTRL_TMR_EN];
            int_en_d = wdat_i[CTRL_INT_EN];
        end

        // Prescaler and counter only advance while enabled; disabling freezes both.
        if (tmr_en_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (tick) begin
            if (count_q == 8'd0) begin
                count_d = reload_q;
                // A zero reload value keeps the counter parked at 0 without ever firing.
                expire_set = (reload_q != 8'd0);
            end else begin
                count_d = count_q - 8'd1;
            end
        end

        // Rising edge of tmr_en restarts a full interval from RELOAD.
        if (ctrl_we_i && !tmr_en_q && wdat_i[CTRL_TMR_EN]) begin
            count_d = reload_q;
            presc_d = '0;
        end

        expire_clr = int_ack_i || (ctrl_we_i && wdat_i[CTRL_EXPIRED]);

        // Set has priority so an expiry coinciding with an acknowledge is never lost.
        if (expire_set) begin
            expired_d = 1'b1;
        end else if (expire_clr) begin
            expired_d = 1'b0;
        end else begin
            expired_d = expired_q;
        end

        int_req_d = expired_q && int_en_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q   <= '0;
            count_q   <= 8'd0;
            reload_q  <= 8'd0;
            tmr_en_q  <= 1'b0;
            int_en_q  <= 1'b0;
            expired_q <= 1'b0;
            int_req_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            tmr_en_q  <= tmr_en_d;
            int_en_q  <= int_en_d;
            expired_q <= expired_d;
            int_req_q <= int_req_d;
        end
    end

    always_comb begin
        ctrl_o         = '0;
        ctrl_o.expired = expired_q;
        ctrl_o.int_en  = int_en_q;
        ctrl_o.tmr_en  = tmr_en_q;
    end

    assign reload_o  = reload_q;
    assign int_req_o = int_req_q;

endmodule : port_timer

// File: rtl/gumnut_port_responder.sv
// -----------------------------------------------------------------------------
// gumnut_port_responder
//   Responder end of the Gumnut CPU I/O port bus. Decodes a 4-register window
//   at BASE_ADDR, completes every selected transfer with a single-cycle ack one
//   cycle after the request, and owns the board I/O: an LED output register,
//   a 2-flop synchronised switch input and, optionally, an interval timer that
//   drives the CPU interrupt request.
//
//   Register window (offset from BASE_ADDR):
//     0 LED    read/write
//     1 SW     read-only, writes are acked and ignored
//     2 RELOAD timer reload value
//     3 CTRL   b0 tmr_en, b1 int_en, b7 expired (write 1 to clear)
//
//   Optional feature macro: GUMNUT_PORT_TIMER_EN
//     defined   : timer, RELOAD and CTRL are implemented.
//     undefined : offsets 2 and 3 still ack, read 8'h00 and ignore writes;
//                 int_req_o is held at 0 and int_ack_i is ignored.
//
// Ports
//   clk_i        in   clock, all state on posedge
//   rst_i        in   synchronous active-high reset
//   port_cyc_i   in   bus cycle in progress
//   port_stb_i   in   transfer request
//   port_we_i    in   1 = write, 0 = read
//   port_adr_i   in   8-bit port address
//   port_dat_i   in   8-bit write data
//   port_dat_o   out  8-bit read data, non-zero only while port_ack_o=1
//   port_ack_o   out  single-cycle transfer-complete pulse
//   int_req_o    out  interrupt request to the CPU
//   int_ack_i    in   interrupt acknowledge pulse from the CPU
//   sw_i         in   asynchronous board switches
//   led_o        out  board LEDs
// -----------------------------------------------------------------------------
module gumnut_port_responder
    import gumnut_port_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         PRESCALE  = 256
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       port_cyc_i,
    input  logic       port_stb_i,
    input  logic       port_we_i,
    input  logic [7:0] port_adr_i,
    input  logic [7:0] port_dat_i,
    output logic [7:0] port_dat_o,
    output logic       port_ack_o,
    output logic       int_req_o,
    input  logic       int_ack_i,
    input  logic [7:0] sw_i,
    output logic [7:0] led_o
);

    logic       ack_q,      ack_d;
    logic [7:0] dat_q,      dat_d;
    logic [7:0] led_q,      led_d;
    logic [7:0] sw_meta_q;
    logic [7:0] sw_sync_q;

    logic       sel;
    logic       fire;
    logic       wr_fire;
    logic       rd_fire;
    logic [1:0] off;
    logic [7:0] rdata;

    logic [7:0] tmr_reload;
    ctrl_t      tmr_ctrl;
    logic       tmr_int_req;

    // BASE_ADDR is 4-aligned, so the low address bits are the register offset.
    assign sel = port_cyc_i && port_stb_i && (port_adr_i[7:2] == BASE_ADDR[7:2]);
    assign off = port_adr_i[1:0];

    // A request is serviced only on the cycle before ack rises; with stb held
    // high the ack cycle itself is skipped, giving one transfer every 2 cycles.
    assign fire    = sel && !ack_q;
    assign wr_fire = fire && port_we_i;
    assign rd_fire = fire && !port_we_i;

    always_comb begin
        rdata = 8'h00;
        case (off)
            OFF_LED:    rdata = led_q;
            OFF_SW:     rdata = sw_sync_q;
            OFF_RELOAD: rdata = tmr_reload;
            OFF_CTRL:   rdata = tmr_ctrl;
            default:    rdata = 8'h00;
        endcase
    end

    always_comb begin
        ack_d = fire;
        dat_d = rd_fire ? rdata : 8'h00;
        led_d = led_q;
        if (wr_fire && (off == OFF_LED)) begin
            led_d = port_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= 8'h00;
            led_q     <= 8'h00;
            sw_meta_q <= 8'h00;
            sw_sync_q <= 8'h00;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            led_q     <= led_d;
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
        end
    end

`ifdef GUMNUT_PORT_TIMER_EN
    port_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .reload_we_i (wr_fire && (off == OFF_RELOAD)),
        .ctrl_we_i   (wr_fire && (off == OFF_CTRL)),
        .wdat_i      (port_dat_i),
        .int_ack_i   (int_ack_i),
        .reload_o    (tmr_reload),
        .ctrl_o      (tmr_ctrl),
        .int_req_o   (tmr_int_req)
    );
`else
    logic unused_timer;
    assign unused_timer = ^{int_ack_i, PRESCALE[0]};

    assign tmr_reload  = 8'h00;
    assign tmr_ctrl    = '0;
    assign tmr_int_req = 1'b0;
`endif

    assign port_ack_o = ack_q;
    assign port_dat_o = dat_q;
    assign led_o      = led_q;
    assign int_req_o  = tmr_int_req;

endmodule : gumnut_port_responder

// File: tb/tb_gumnut_port_responder.sv
module tb_gumnut_port_responder;

    localparam logic [7:0] BASE  = 8'h40;
    localparam int         PRESC = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       port_cyc_i = 1'b0;
    logic       port_stb_i = 1'b0;
    logic       port_we_i = 1'b0;
    logic [7:0] port_adr_i = 8'h00;
    logic [7:0] port_dat_i = 8'h00;
    logic [7:0] port_dat_o;
    logic       port_ack_o;
    logic       int_req_o;
    logic       int_ack_i = 1'b0;
    logic [7:0] sw_i = 8'h00;
    logic [7:0] led_o;

    int errors = 0;
    int checks = 0;
    int cycle_q = 0;
    logic [7:0] exp_q[$];

    gumnut_port_responder #(
        .BASE_ADDR (BASE),
        .PRESCALE  (PRESC)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .port_cyc_i (port_cyc_i),
        .port_stb_i (port_stb_i),
        .port_we_i  (port_we_i),
        .port_adr_i (port_adr_i),
        .port_dat_i (port_dat_i),
        .port_dat_o (port_dat_o),
        .port_ack_o (port_ack_o),
        .int_req_o  (int_req_o),
        .int_ack_i  (int_ack_i),
        .sw_i       (sw_i),
        .led_o      (led_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_q <= cycle_q + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus transfer with stb for a single cycle. Reads push their expected
    // data into the scoreboard when issued and pop it when the ack arrives.
    task automatic do_xfer(input logic w, input logic [7:0] adr, input logic [7:0] dat,
                           input logic exp_ack, input logic [7:0] exp_dat, input string name);
        logic [7:0] e;
        @(negedge clk);
        port_cyc_i = 1'b1; port_stb_i = 1'b1; port_we_i = w;
        port_adr_i = adr;  port_dat_i = dat;
        if (!w && exp_ack) exp_q.push_back(exp_dat);
        @(negedge clk);
        port_cyc_i = 1'b0; port_stb_i = 1'b0; port_we_i = 1'b0;
        checks++;
        if (port_ack_o !== exp_ack) begin
            errors++;
            $display("FAIL %s ack: got %b expected %b", name, port_ack_o, exp_ack);
        end
        if (!w && exp_ack) begin
            e = exp_q.pop_front();
            checks++;
            if (port_dat_o !== e) begin
                errors++;
                $display("FAIL %s data: got %h expected %h", name, port_dat_o, e);
            end
        end else if (!exp_ack) begin
            checks++;
            if (port_dat_o !== 8'h00) begin
                errors++;
                $display("FAIL %s unselected data: got %h expected 00", name, port_dat_o);
            end
        end
        @(negedge clk);
        checks++;
        if (port_ack_o !== 1'b0 || port_dat_o !== 8'h00) begin
            errors++;
            $display("FAIL %s after ack: ack=%b dat=%h expected 0/00", name, port_ack_o, port_dat_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (port_ack_o !== 1'b0) begin errors++; $display("FAIL reset ack: got %b expected 0", port_ack_o); end
        checks++; if (port_dat_o !== 8'h00) begin errors++; $display("FAIL reset dat: got %h expected 00", port_dat_o); end
        checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL reset led: got %h expected 00", led_o); end
        checks++; if (int_req_o !== 1'b0) begin errors++; $display("FAIL reset int_req: got %b expected 0", int_req_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_led();
        do_xfer(1'b1, BASE + 8'd0, 8'hA5, 1'b1, 8'h00, "led_wr");
        checks++;
        if (led_o !== 8'hA5) begin errors++; $display("FAIL led_o: got %h expected a5", led_o); end
        do_xfer(1'b0, BASE + 8'd0, 8'h00, 1'b1, 8'hA5, "led_rd");
    endtask

    task automatic test_sw_decode();
        @(negedge clk); sw_i = 8'h3C;
        repeat (3) @(negedge clk);
        do_xfer(1'b0, BASE + 8'd1, 8'h00, 1'b1, 8'h3C, "sw_rd");
        do_xfer(1'b1, BASE + 8'd1, 8'hFF, 1'b1, 8'h00, "sw_wr_ignored");
        do_xfer(1'b0, BASE + 8'd1, 8'h00, 1'b1, 8'h3C, "sw_rd_after_wr");
        // New switch value not yet through both synchroniser flops.
        sw_i = 8'hC3;
        do_xfer(1'b0, BASE + 8'd1, 8'h00, 1'b1, 8'h3C, "sw_sync_latency");
        do_xfer(1'b0, BASE + 8'd1, 8'h00, 1'b1, 8'hC3, "sw_rd_new");
        do_xfer(1'b0, BASE + 8'd4, 8'h00, 1'b0, 8'h00, "unsel_base4");
        do_xfer(1'b1, 8'h00, 8'h11, 1'b0, 8'h00, "unsel_wr_00");
        checks++;
        if (led_o !== 8'hA5) begin errors++; $display("FAIL unsel_wr led_o: got %h expected a5", led_o); end
    endtask

    // Wait for int_req_o to rise, bounded; returns cycles since start_cyc or -1.
    task automatic wait_irq(input int start_cyc, output int dly);
        dly = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (int_req_o === 1'b1) begin
                dly = cycle_q - start_cyc;
                break;
            end
        end
    endtask

    task automatic ctrl_write_at_edge(input logic [7:0] dat, output int edge_cyc);
        @(negedge clk);
        port_cyc_i = 1'b1; port_stb_i = 1'b1; port_we_i = 1'b1;
        port_adr_i = BASE + 8'd3; port_dat_i = dat;
        @(posedge clk); #1;
        edge_cyc = cycle_q;
        port_cyc_i = 1'b0; port_stb_i = 1'b0; port_we_i = 1'b0;
    endtask

`ifdef GUMNUT_PORT_TIMER_EN
    task automatic test_timer();
        int e_cyc;
        int dly;
        do_xfer(1'b1, BASE + 8'd2, 8'h03, 1'b1, 8'h00, "reload_wr");
        do_xfer(1'b0, BASE + 8'd2, 8'h00, 1'b1, 8'h03, "reload_rd");
        ctrl_write_at_edge(8'h03, e_cyc);
        wait_irq(e_cyc, dly);
        checks++;
        if (dly !== 17) begin errors++; $display("FAIL timer first fire delay: got %0d expected 17", dly); end
        @(negedge clk); int_ack_i = 1'b1;
        @(negedge clk); int_ack_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (int_req_o !== 1'b0) begin errors++; $display("FAIL timer int_ack clear: got %b expected 0", int_req_o); end
        wait_irq(e_cyc, dly);
        checks++;
        if (dly !== 33) begin errors++; $display("FAIL timer refire delay: got %0d expected 33", dly); end
        do_xfer(1'b0, BASE + 8'd3, 8'h00, 1'b1, 8'h83, "ctrl_rd_expired");
    endtask

    task automatic test_ack_on_tick();
        int e_cyc;
        do_xfer(1'b1, BASE + 8'd3, 8'h80, 1'b1, 8'h00, "ctrl_w1c_disable");
        checks++;
        if (int_req_o !== 1'b0) begin errors++; $display("FAIL w1c int_req: got %b expected 0", int_req_o); end
        do_xfer(1'b0, BASE + 8'd3, 8'h00, 1'b1, 8'h00, "ctrl_rd_cleared");
        ctrl_write_at_edge(8'h03, e_cyc);
        repeat (15) @(posedge clk);
        #1 int_ack_i = 1'b1;
        @(posedge clk);
        #1 int_ack_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (int_req_o !== 1'b1) begin errors++; $display("FAIL set-wins int_req: got %b expected 1", int_req_o); end
        do_xfer(1'b0, BASE + 8'd3, 8'h00, 1'b1, 8'h83, "ctrl_rd_set_wins");
    endtask
`else
    task automatic test_no_timer();
        do_xfer(1'b1, BASE + 8'd2, 8'h03, 1'b1, 8'h00, "nt_reload_wr");
        do_xfer(1'b1, BASE + 8'd3, 8'h03, 1'b1, 8'h00, "nt_ctrl_wr");
        do_xfer(1'b0, BASE + 8'd3, 8'h00, 1'b1, 8'h00, "nt_ctrl_rd");
        do_xfer(1'b0, BASE + 8'd2, 8'h00, 1'b1, 8'h00, "nt_reload_rd");
        @(negedge clk); int_ack_i = 1'b1;
        @(negedge clk); int_ack_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (int_req_o !== 1'b0) begin errors++; $display("FAIL nt int_req cycle %0d: got %b expected 0", i, int_req_o); end
        end
    endtask
`endif

    task automatic test_back_to_back();
        int acks;
        logic [7:0] e;
        // Write with stb held for 6 cycles
        @(negedge clk);
        port_cyc_i = 1'b1; port_stb_i = 1'b1; port_we_i = 1'b1;
        port_adr_i = BASE; port_dat_i = 8'h5A;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (port_ack_o === 1'b1) acks++;
        end
        port_cyc_i = 1'b0; port_stb_i = 1'b0; port_we_i = 1'b0;
        checks++;
        if (acks !== 3) begin errors++; $display("FAIL held_stb ack count: got %0d expected 3", acks); end
        checks++;
        if (led_o !== 8'h5A) begin errors++; $display("FAIL held_stb led_o: got %h expected 5a", led_o); end
        // Read with stb held for 4 cycles: two acks, each drained from the scoreboard
        @(negedge clk);
        port_cyc_i = 1'b1; port_stb_i = 1'b1; port_adr_i = BASE;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (port_ack_o === 1'b1) begin
                acks++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (port_dat_o !== e) begin errors++; $display("FAIL held_rd data: got %h expected %h", port_dat_o, e); end
                end
            end
        end
        port_cyc_i = 1'b0; port_stb_i = 1'b0;
        checks++;
        if (acks !== 2 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL held_rd acks: got %0d (left %0d) expected 2 (left 0)", acks, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        port_cyc_i = 1'b1; port_stb_i = 1'b1; port_we_i = 1'b1;
        port_adr_i = BASE; port_dat_i = 8'h77;
        rst_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (port_ack_o !== 1'b0) begin errors++; $display("FAIL rst_mid ack: got %b expected 0", port_ack_o); end
        @(negedge clk);
        port_cyc_i = 1'b0; port_stb_i = 1'b0; port_we_i = 1'b0;
        rst_i = 1'b0;
        checks++;
        if (led_o !== 8'h00) begin errors++; $display("FAIL rst_mid led_o: got %h expected 00", led_o); end
        checks++;
        if (int_req_o !== 1'b0) begin errors++; $display("FAIL rst_mid int_req: got %b expected 0", int_req_o); end
        do_xfer(1'b0, BASE + 8'd3, 8'h00, 1'b1, 8'h00, "rst_mid_ctrl");
        do_xfer(1'b0, BASE + 8'd2, 8'h00, 1'b1, 8'h00, "rst_mid_reload");
        repeat (20) @(negedge clk);
        checks++;
        if (int_req_o !== 1'b0) begin errors++; $display("FAIL rst_mid timer idle: got %b expected 0", int_req_o); end
    endtask

    initial begin
        test_reset();
        test_led();
        test_sw_decode();
`ifdef GUMNUT_PORT_TIMER_EN
        test_timer();
        test_ack_on_tick();
`else
        test_no_timer();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_gumnut_port_responder
